// File: rtl/jtframe_db9_pkg.sv
// Shared types and index constants for the DB9 Mega Drive pad reader.
package jtframe_db9_pkg;

    typedef enum logic [1:0] {
        PAD_ATARI = 2'd0,
        PAD_MD3   = 2'd1,
        PAD_MD6   = 2'd2
    } pad_type_t;

    // Raw DB9 pin positions inside a port's 6-bit bus
    localparam int PIN_R = 0;
    localparam int PIN_L = 1;
    localparam int PIN_D = 2;
    localparam int PIN_U = 3;
    localparam int PIN_6 = 4;
    localparam int PIN_9 = 5;

    // Decoded button positions inside a port's 12-bit vector
    localparam int BTN_R     = 0;
    localparam int BTN_L     = 1;
    localparam int BTN_D     = 2;
    localparam int BTN_U     = 3;
    localparam int BTN_B     = 4;
    localparam int BTN_C     = 5;
    localparam int BTN_A     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_X     = 8;
    localparam int BTN_Y     = 9;
    localparam int BTN_Z     = 10;
    localparam int BTN_MODE  = 11;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_PH0    = 4'd1,
        ST_PH1    = 4'd2,
        ST_PH2    = 4'd3,
        ST_PH3    = 4'd4,
        ST_PH4    = 4'd5,
        ST_PH5    = 4'd6,
        ST_PH6    = 4'd7,
        ST_PH7    = 4'd8,
        ST_UPDATE = 4'd9
    } state_t;

    // SELECT is pulled low only in the odd phases
    function automatic logic sel_level(input state_t st);
        return !(st inside {ST_PH1, ST_PH3, ST_PH5, ST_PH7});
    endfunction

endpackage

// File: rtl/jtframe_db9_port.sv
// One DB9 port: phase samples, pad-type detection, decode and output register.
// JTFRAME_DB9_DEBOUNCE_EN adds a previous-scan register that gates the output load.
module jtframe_db9_port
    import jtframe_db9_pkg::*;
(
    input  logic        clk,
    input  logic        srst,
    input  logic [5:0]  pins,
    input  logic [3:0]  sample,
    input  logic        update,
    output logic [11:0] buttons,
    output logic [1:0]  pad_type
);

    // Sample slots: 0 = PH0, 1 = PH1, 2 = PH5, 3 = PH6 (pins still active-low)
    logic [5:0]  smp_reg [4];
    logic        md;
    logic        md6;
    logic [11:0] dec_next;
    pad_type_t   type_next;
    logic [11:0] buttons_reg;
    logic [1:0]  pad_type_reg;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (srst) begin
                smp_reg[i] <= '1;
            end else if (sample[i]) begin
                smp_reg[i] <= pins;
            end
        end
    end

    always_comb begin
        md  = !smp_reg[1][PIN_L] && !smp_reg[1][PIN_R];
        md6 = md && (smp_reg[2][3:0] == 4'd0);

        dec_next            = '0;
        dec_next[3:0]       = ~smp_reg[0][3:0];
        dec_next[BTN_B]     = ~smp_reg[0][PIN_6];
        dec_next[BTN_C]     = ~smp_reg[0][PIN_9];
        if (md) begin
            dec_next[BTN_A]     = ~smp_reg[1][PIN_6];
            dec_next[BTN_START] = ~smp_reg[1][PIN_9];
        end
        if (md6) begin
            dec_next[BTN_Z]    = ~smp_reg[3][PIN_U];
            dec_next[BTN_Y]    = ~smp_reg[3][PIN_D];
            dec_next[BTN_X]    = ~smp_reg[3][PIN_L];
            dec_next[BTN_MODE] = ~smp_reg[3][PIN_R];
        end

        type_next = md6 ? PAD_MD6 : (md ? PAD_MD3 : PAD_ATARI);
    end

`ifdef JTFRAME_DB9_DEBOUNCE_EN
    logic [13:0] prev_reg;

    // Publish only a decode that survived two consecutive scans unchanged
    always_ff @(posedge clk) begin
        if (srst) begin
            prev_reg     <= '0;
            buttons_reg  <= '0;
            pad_type_reg <= PAD_ATARI;
        end else if (update) begin
            prev_reg <= {type_next, dec_next};
            if ({type_next, dec_next} == prev_reg) begin
                buttons_reg  <= dec_next;
                pad_type_reg <= type_next;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (srst) begin
            buttons_reg  <= '0;
            pad_type_reg <= PAD_ATARI;
        end else if (update) begin
            buttons_reg  <= dec_next;
            pad_type_reg <= type_next;
        end
    end
`endif

    assign buttons  = buttons_reg;
    assign pad_type = pad_type_reg;

endmodule

// File: rtl/jtframe_db9_mdpad.sv
// Multi-port DB9 reader running the Mega Drive 6-button SELECT sequence.
// Optional macro JTFRAME_DB9_DEBOUNCE_EN enables two-scan output debouncing.
module jtframe_db9_mdpad
    import jtframe_db9_pkg::*;
#(
    parameter int PORTS     = 2,
    parameter int PHASE_DIV = 480,
    parameter int SCAN_DIV  = 96000
) (
    input  logic                  clk_sys,
    input  logic                  rst,
    input  logic [PORTS*6-1:0]    joy_pins,
    output logic                  joy_sel,
    output logic [PORTS*12-1:0]   joy_out,
    output logic [PORTS*2-1:0]    pad_type,
    output logic                  joy_valid
);

    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int PW = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(PHASE_DIV - 1);

    if (SCAN_DIV < 8 * PHASE_DIV + 2) begin : g_bad_scan
        $error("jtframe_db9_mdpad: SCAN_DIV must be >= 8*PHASE_DIV+2");
    end
    if (PORTS < 1 || PORTS > 4) begin : g_bad_ports
        $error("jtframe_db9_mdpad: PORTS must be 1..4");
    end

    logic [PORTS*6-1:0] pins_meta_reg;
    logic [PORTS*6-1:0] pins_sync_reg;
    logic [SW-1:0]      scan_cnt_reg;
    logic [PW-1:0]      phase_cnt_reg;
    logic [PW-1:0]      phase_cnt_next;
    state_t             state_reg;
    state_t             state_next;
    logic               joy_valid_reg;
    logic               phase_last;
    logic [3:0]         sample;
    logic               update;

    // Pins are asynchronous to clk_sys; idle level of an unplugged pin is high
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            pins_meta_reg <= '1;
            pins_sync_reg <= '1;
        end else begin
            pins_meta_reg <= joy_pins;
            pins_sync_reg <= pins_meta_reg;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            scan_cnt_reg <= '0;
        end else if (scan_cnt_reg == SCAN_LAST) begin
            scan_cnt_reg <= '0;
        end else begin
            scan_cnt_reg <= scan_cnt_reg + 1'b1;
        end
    end

    assign phase_last = (phase_cnt_reg == PHASE_LAST);

    always_comb begin
        state_next     = state_reg;
        phase_cnt_next = phase_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (scan_cnt_reg == SCAN_LAST) begin
                    state_next     = ST_PH0;
                    phase_cnt_next = '0;
                end
            end
            ST_UPDATE: state_next = ST_IDLE;
            default: begin
                if (phase_last) begin
                    phase_cnt_next = '0;
                    state_next     = (state_reg == ST_PH7) ? ST_UPDATE
                                                           : state_t'(state_reg + 4'd1);
                end else begin
                    phase_cnt_next = phase_cnt_reg + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            phase_cnt_reg <= '0;
            joy_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            phase_cnt_reg <= phase_cnt_next;
            joy_valid_reg <= (state_reg == ST_UPDATE);
        end
    end

    // Sampling happens on the last cycle of a phase, after the pad has settled
    assign sample[0] = (state_reg == ST_PH0) && phase_last;
    assign sample[1] = (state_reg == ST_PH1) && phase_last;
    assign sample[2] = (state_reg == ST_PH5) && phase_last;
    assign sample[3] = (state_reg == ST_PH6) && phase_last;
    assign update    = (state_reg == ST_UPDATE);

    assign joy_sel   = sel_level(state_reg);
    assign joy_valid = joy_valid_reg;

    for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
        jtframe_db9_port u_port (
            .clk      (clk_sys),
            .srst     (rst),
            .pins     (pins_sync_reg[gi*6 +: 6]),
            .sample   (sample),
            .update   (update),
            .buttons  (joy_out[gi*12 +: 12]),
            .pad_type (pad_type[gi*2 +: 2])
        );
    end

endmodule

// File: tb/tb_jtframe_db9_mdpad.sv
// Bench for jtframe_db9_mdpad: behavioural pad models on each port, expected
// outputs derived from the pad type and the pressed-button set.
module tb_jtframe_db9_mdpad;

    localparam int PORTS = 2;
    localparam int PH    = 8;
    localparam int SCAN  = 120;
    localparam int FIRST = SCAN + 8 * PH + 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [PORTS*6-1:0]  joy_pins;
    logic                joy_sel;
    logic [PORTS*12-1:0] joy_out;
    logic [PORTS*2-1:0]  pad_type;
    logic                joy_valid;

    int checks   = 0;
    int failures = 0;

    // Pad configuration: type -1 = unplugged, 0 Atari, 1 MD3, 2 MD6
    int          ptype [PORTS] = '{default: -1};
    logic [11:0] pbtn  [PORTS] = '{default: 12'h000};

    // SELECT falling-edge counter as seen by a 6-button pad; clears after a long high
    int   nfall    = 0;
    int   high_cnt = 0;
    logic sel_d    = 1'b1;

    always #5 clk = ~clk;

    jtframe_db9_mdpad #(
        .PORTS     (PORTS),
        .PHASE_DIV (PH),
        .SCAN_DIV  (SCAN)
    ) dut (
        .clk_sys   (clk),
        .rst       (rst),
        .joy_pins  (joy_pins),
        .joy_sel   (joy_sel),
        .joy_out   (joy_out),
        .pad_type  (pad_type),
        .joy_valid (joy_valid)
    );

    always @(posedge clk) begin
        sel_d <= joy_sel;
        if (sel_d && !joy_sel) nfall <= nfall + 1;
        else if (high_cnt > 2 * PH) nfall <= 0;
        high_cnt <= joy_sel ? high_cnt + 1 : 0;
    end

    // Pin levels a pad of type t presents; act bits mean "pin pulled low"
    function automatic logic [5:0] pad_pins(input int t, input logic [11:0] b,
                                            input logic sel, input int nf);
        logic [5:0] act;
        if (t < 0) return 6'h3F;
        if (t == 0) begin
            act = b[5:0];
        end else if (sel) begin
            if (t == 2 && nf == 3) act = {b[5], b[4], b[10], b[9], b[8], b[11]};
            else                   act = b[5:0];
        end else begin
            if (t == 2 && nf == 3) act = {b[7], b[6], 4'b1111};
            else                   act = {b[7], b[6], b[3], b[2], 2'b11};
        end
        return ~act;
    endfunction

    always_comb begin
        for (int p = 0; p < PORTS; p++)
            joy_pins[p*6 +: 6] = pad_pins(ptype[p], pbtn[p], joy_sel, nfall);
    end

    function automatic logic [11:0] exp_out(input int t, input logic [11:0] b);
        case (t)
            0:       return b & 12'h03F;
            1:       return b & 12'h0FF;
            2:       return b;
            default: return 12'h000;
        endcase
    endfunction

    function automatic logic [1:0] exp_type(input int t);
        return (t < 0) ? 2'd0 : 2'(t);
    endfunction

    // Opposing directions are never pressed together on a real pad
    function automatic logic [11:0] rand_btn();
        logic [11:0] b;
        b = 12'($urandom);
        if (b[0] && b[1]) b[1] = 1'b0;
        if (b[2] && b[3]) b[2] = 1'b0;
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int cycles);
        bit got;
        got    = 1'b0;
        cycles = 0;
        while (!got && cycles < 3 * SCAN) begin
            @(negedge clk);
            cycles++;
            if (joy_valid) got = 1'b1;
        end
        check("valid_seen", 32'(got), 32'd1);
    endtask

    task automatic check_ports(input string tag);
        for (int p = 0; p < PORTS; p++) begin
            $display("txn %s port%0d type=%0d btn=%03h out=%03h pad_type=%0d",
                     tag, p, ptype[p], pbtn[p], joy_out[p*12 +: 12], pad_type[p*2 +: 2]);
            check($sformatf("%s_out%0d", tag, p), 32'(joy_out[p*12 +: 12]),
                  32'(exp_out(ptype[p], pbtn[p])));
            check($sformatf("%s_type%0d", tag, p), 32'(pad_type[p*2 +: 2]),
                  32'(exp_type(ptype[p])));
        end
    endtask

    // Change the pads right after a publish so the next scan sees them whole
    task automatic apply(input int t0, input logic [11:0] b0, input int t1,
                         input logic [11:0] b1, input string tag);
        int c;
        ptype[0] = t0; pbtn[0] = b0;
        ptype[1] = t1; pbtn[1] = b1;
        wait_valid(c);
`ifdef JTFRAME_DB9_DEBOUNCE_EN
        wait_valid(c);
`endif
        check_ports(tag);
    endtask

    initial begin
        int   c;
        int   lows;
        int   run;
        int   bad;
        int   falls;
        bit   got;
        logic prev;

        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_sel",   32'(joy_sel),   32'd1);
        check("rst_out",   32'(joy_out),   32'd0);
        check("rst_type",  32'(pad_type),  32'd0);
        check("rst_valid", 32'(joy_valid), 32'd0);

        rst = 1'b0;
        wait_valid(c);
        check("first_valid_cycle", 32'(c), 32'(FIRST));
        check_ports("unplugged");

        apply(0, 12'h018, 1, 12'h0C0, "atari_md3");
        apply(2, 12'h901, -1, 12'h000, "md6");

        // One full scan of SELECT: four low pulses, each exactly one phase long
        lows = 0; run = 0; bad = 0; got = 1'b0;
        for (int i = 0; i < 3 * SCAN && !got; i++) begin
            @(negedge clk);
            if (!joy_sel) begin
                run++;
            end else begin
                if (run > 0) begin
                    lows++;
                    if (run != PH) bad++;
                end
                run = 0;
            end
            if (joy_valid) got = 1'b1;
        end
        check("sel_scan_done", 32'(got), 32'd1);
        check("sel_low_pulses", 32'(lows), 32'd4);
        check("sel_bad_len", 32'(bad), 32'd0);
        check_ports("md6_hold");

        // Reset in the middle of PH3
        falls = 0; prev = joy_sel;
        for (int i = 0; i < 3 * SCAN && falls < 2; i++) begin
            @(negedge clk);
            if (prev && !joy_sel) falls++;
            prev = joy_sel;
        end
        check("ph3_reached", 32'(falls), 32'd2);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_sel",   32'(joy_sel),   32'd1);
        check("midrst_out",   32'(joy_out),   32'd0);
        check("midrst_type",  32'(pad_type),  32'd0);
        check("midrst_valid", 32'(joy_valid), 32'd0);
        rst = 1'b0;
        wait_valid(c);
        check("midrst_latency_ok", 32'(c >= FIRST - 3 && c <= FIRST + 3), 32'd1);
`ifdef JTFRAME_DB9_DEBOUNCE_EN
        wait_valid(c);
`endif
        check_ports("after_rst");

        for (int n = 0; n < 12; n++) begin
            apply($urandom_range(0, 3) - 1, rand_btn(),
                  $urandom_range(0, 3) - 1, rand_btn(), $sformatf("rand%0d", n));
        end

`ifdef JTFRAME_DB9_DEBOUNCE_EN
        apply(0, 12'h000, -1, 12'h000, "db_base");
        pbtn[0] = 12'h010;
        wait_valid(c);
        pbtn[0] = 12'h000;
        wait_valid(c);
        check("db_glitch_out", 32'(joy_out[11:0]), 32'h000);
        pbtn[0] = 12'h010;
        wait_valid(c);
        check("db_first_scan", 32'(joy_out[11:0]), 32'h000);
        wait_valid(c);
        check("db_second_scan", 32'(joy_out[11:0]), 32'h010);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
